// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data memory between
// port A (pipeline MEM stage, default priority) and port B (loader/DMA).
// A wait counter forces B ahead of A after B_MAX_WAIT denied cycles, and
// B may lock the memory for bursts of up to BURST_MAX grants while A waits.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata       port A request bundle
//   a_gnt, a_rvalid, a_rdata        port A grant (comb) and read return
//   b_req/b_we/b_addr/b_wdata       port B request bundle
//   b_lock                          port B burst ownership request
//   b_gnt, b_rvalid, b_rdata        port B grant (comb) and read return
//   mem_en/mem_we/mem_addr/mem_wdata memory command (comb, follows grant)
//   mem_rdata                       memory read data, one cycle after read
module dmem_arbiter #(
  parameter int unsigned DATA_BITS  = 64,
  parameter int unsigned ADDR_BITS  = 64,
  parameter int unsigned B_MAX_WAIT = 4,
  parameter int unsigned BURST_MAX  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [DATA_BITS-1:0] a_wdata,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [DATA_BITS-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [DATA_BITS-1:0] b_wdata,
  input  logic                 b_lock,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [DATA_BITS-1:0] b_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata
);

  localparam int unsigned CNT_BITS = 8;
  localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;
  localparam logic [CNT_BITS-1:0] WAIT_LIM  = CNT_BITS'(B_MAX_WAIT);
  localparam logic [CNT_BITS-1:0] BURST_LIM = CNT_BITS'(BURST_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_A  = 2'd1,
    OWN_B  = 2'd2,
    LOCK_B = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_BITS-1:0]  wait_q, wait_d;
  logic [CNT_BITS-1:0]  burst_q, burst_d;
  logic                 tag_a_q, tag_a_d;
  logic                 tag_b_q, tag_b_d;
  logic [DATA_BITS-1:0] a_rdata_q, b_rdata_q;
  logic                 gnt_a, gnt_b;

  // State register and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      burst_q   <= '0;
      tag_a_q   <= 1'b0;
      tag_b_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      burst_q   <= burst_d;
      tag_a_q   <= tag_a_d;
      tag_b_q   <= tag_b_d;
      a_rdata_q <= a_rdata;
      b_rdata_q <= b_rdata;
    end
  end

  // Grant decision, next state, counter and read-tag updates
  always_comb begin
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    state_d = IDLE;
    wait_d  = '0;
    burst_d = burst_q;
    tag_a_d = 1'b0;
    tag_b_d = 1'b0;

    if (!rst) begin
      if (state_q == LOCK_B && b_req && b_lock && (!a_req || burst_q < BURST_LIM))
        gnt_b = 1'b1;
      else if (b_req && wait_q >= WAIT_LIM)
        gnt_b = 1'b1;
      else if (a_req)
        gnt_a = 1'b1;
      else if (b_req)
        gnt_b = 1'b1;
    end

    if (gnt_a)
      state_d = OWN_A;
    else if (gnt_b)
      state_d = b_lock ? LOCK_B : OWN_B;

    if (b_req && !gnt_b)
      wait_d = (wait_q == CNT_MAX) ? wait_q : wait_q + CNT_BITS'(1);

    // Only B grants made while already locked and A is waiting use up the burst
    if (state_d != LOCK_B)
      burst_d = '0;
    else if (state_q != LOCK_B)
      burst_d = '0;
    else if (a_req && burst_q != CNT_MAX)
      burst_d = burst_q + CNT_BITS'(1);

    tag_a_d = gnt_a && !a_we;
    tag_b_d = gnt_b && !b_we;
  end

  // Port handshakes, memory command and read return
  always_comb begin
    a_gnt     = gnt_a;
    b_gnt     = gnt_b;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    if (gnt_a) begin
      mem_en    = 1'b1;
      mem_we    = a_we;
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
    end else if (gnt_b) begin
      mem_en    = 1'b1;
      mem_we    = b_we;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end

    // A reset in the return cycle drops the pending read
    a_rvalid = tag_a_q && !rst;
    b_rvalid = tag_b_q && !rst;
    a_rdata  = a_rvalid ? mem_rdata : a_rdata_q;
    b_rdata  = b_rvalid ? mem_rdata : b_rdata_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous memory model and a
// read-return scoreboard keyed by the cycle each read is due.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        a_req, a_we, a_gnt, a_rvalid;
  logic [63:0] a_addr, a_wdata, a_rdata;
  logic        b_req, b_we, b_lock, b_gnt, b_rvalid;
  logic [63:0] b_addr, b_wdata, b_rdata;
  logic        mem_en, mem_we;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_lock   (b_lock),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous memory, 64 words
  logic [63:0] mem [64];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[5:0]];
    end
  end

  typedef struct {
    int          due;
    logic        port;
    logic [63:0] data;
  } exp_t;

  exp_t        q[$];
  logic [63:0] shadow [64];
  logic [63:0] last_a, last_b;
  int          n_assert;
  int          n_fail;
  int          cycle;
  int          nb;
  logic        eb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // One clock: check outputs at negedge against expected grants, update scoreboard
  task automatic cyc(input logic ea, input logic ebg);
    exp_t        e;
    logic        va, vb;
    logic [63:0] da, db;
    @(negedge clk);
    chk("a_gnt", 64'(a_gnt), 64'(ea));
    chk("b_gnt", 64'(b_gnt), 64'(ebg));
    chk("mem_en", 64'(mem_en), 64'(ea | ebg));
    if (ea) begin
      chk("mem_we", 64'(mem_we), 64'(a_we));
      chk("mem_addr", mem_addr, a_addr);
      chk("mem_wdata", mem_wdata, a_wdata);
    end else if (ebg) begin
      chk("mem_we", 64'(mem_we), 64'(b_we));
      chk("mem_addr", mem_addr, b_addr);
      chk("mem_wdata", mem_wdata, b_wdata);
    end else begin
      chk("mem_we_idle", 64'(mem_we), 64'd0);
      chk("mem_addr_idle", mem_addr, 64'd0);
      chk("mem_wdata_idle", mem_wdata, 64'd0);
    end
    va = 1'b0;
    vb = 1'b0;
    if (rst) begin
      q.delete();
    end else begin
      da = last_a;
      db = last_b;
      if (q.size() > 0 && q[0].due == cycle) begin
        e = q.pop_front();
        if (e.port) begin vb = 1'b1; db = e.data; end
        else        begin va = 1'b1; da = e.data; end
      end
      chk("a_rdata", a_rdata, da);
      chk("b_rdata", b_rdata, db);
      last_a = da;
      last_b = db;
    end
    chk("a_rvalid", 64'(a_rvalid), 64'(va));
    chk("b_rvalid", 64'(b_rvalid), 64'(vb));
    if (rst) begin
      last_a = '0;
      last_b = '0;
    end
    if (ea) begin
      if (a_we) shadow[a_addr[5:0]] = a_wdata;
      else      q.push_back('{cycle + 1, 1'b0, shadow[a_addr[5:0]]});
    end else if (ebg) begin
      if (b_we) shadow[b_addr[5:0]] = b_wdata;
      else      q.push_back('{cycle + 1, 1'b1, shadow[b_addr[5:0]]});
    end
    cycle++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cycle    = 0;
    last_a   = '0;
    last_b   = '0;
    mem_rdata = '0;
    for (int i = 0; i < 64; i++) begin
      mem[i]    = {32'hC0DE_0000 + 32'(i), 32'h1234_0000 + 32'(i)};
      shadow[i] = {32'hC0DE_0000 + 32'(i), 32'h1234_0000 + 32'(i)};
    end

    // Reset held with both ports requesting: no grants until it falls
    rst = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 64'h10; a_wdata = 64'h0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 64'h20; b_wdata = 64'h0; b_lock = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b1, 1'b0);
    a_req = 1'b0; b_req = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);

    // B writes, then A reads the same address on the next cycle
    b_req = 1'b1; b_we = 1'b1; b_addr = 64'h10; b_wdata = 64'hDEADBEEF;
    cyc(1'b0, 1'b1);
    b_req = 1'b0; b_we = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 64'h10;
    cyc(1'b1, 1'b0);
    a_req = 1'b0;
    cyc(1'b0, 1'b0);

    // Both requesting continuously: B forced ahead every fifth cycle
    a_req = 1'b1; a_addr = 64'h01;
    b_req = 1'b1; b_addr = 64'h02; b_lock = 1'b0;
    for (int c = 0; c < 10; c++) cyc(c != 4 && c != 9, c == 4 || c == 9);
    a_req = 1'b0; b_req = 1'b0;
    cyc(1'b0, 1'b0);

    // Locked B burst of 12 reads while A keeps requesting
    a_req = 1'b1; a_addr = 64'h03;
    b_req = 1'b1; b_lock = 1'b1;
    nb = 0;
    for (int c = 0; c < 21; c++) begin
      eb = (c >= 4 && c <= 12) || (c >= 17 && c <= 19);
      if (nb == 12) b_req = 1'b0;
      b_addr = 64'h20 + 64'(nb);
      cyc(!eb, eb);
      if (eb) nb++;
    end
    a_req = 1'b0; b_lock = 1'b0;
    cyc(1'b0, 1'b0);

    // Alternating A, B, A reads on consecutive cycles
    a_req = 1'b1; a_addr = 64'h04;
    cyc(1'b1, 1'b0);
    a_req = 1'b0;
    b_req = 1'b1; b_addr = 64'h05;
    cyc(1'b0, 1'b1);
    b_req = 1'b0;
    a_req = 1'b1; a_addr = 64'h06;
    cyc(1'b1, 1'b0);
    a_req = 1'b0;
    cyc(1'b0, 1'b0);

    // Reset in the return cycle of an A read drops the read
    a_req = 1'b1; a_addr = 64'h07;
    cyc(1'b1, 1'b0);
    a_req = 1'b0;
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    a_req = 1'b1; a_addr = 64'h08;
    cyc(1'b1, 1'b0);
    a_req = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
